// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF timestep scheduler.
// Saturation helpers work on a 64-bit carrier so one function serves any WIDTH up to 62.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } lif_state_e;

    // Minimum-1 bit width able to index/count n distinct values.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x,
                                                     input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        w);
        return sat_clamp(a + b, w);
    endfunction

endpackage

// File: rtl/lif_timestep_scheduler_if.sv
// Current-write and spike-event signals between the scheduler and its neighbours.
// slave = scheduler side; master = stimulus / router side.
interface lif_timestep_scheduler_if #(
    parameter int N_NEURONS = 16,
    parameter int WIDTH     = 16
) ();
    localparam int IW = lif_pkg::cnt_width(N_NEURONS);

    logic                    cur_wr_en;
    logic [IW-1:0]           cur_wr_idx;
    logic signed [WIDTH-1:0] cur_wr_data;
    logic                    spk_valid;
    logic [IW-1:0]           spk_idx;
    logic                    spk_ready;

    modport master (
        output cur_wr_en, cur_wr_idx, cur_wr_data, spk_ready,
        input  spk_valid, spk_idx
    );

    modport slave (
        input  cur_wr_en, cur_wr_idx, cur_wr_data, spk_ready,
        output spk_valid, spk_idx
    );
endinterface

// File: rtl/lif_update_unit.sv
// Combinational single-neuron LIF update: leak, integrate, saturate, threshold, refractory.
// Zero latency; no handshake, the caller decides when the result is committed.
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int WIDTH             = 16,
    parameter int THRESHOLD         = 1000,
    parameter int LEAK              = 10,
    parameter int RESET_POTENTIAL   = 0,
    parameter int REFRACTORY_CYCLES = 10,
    parameter int RW                = 4
) (
    input  logic signed [WIDTH-1:0] v_in,
    input  logic signed [WIDTH-1:0] a_in,
    input  logic [RW-1:0]           r_in,
    output logic signed [WIDTH-1:0] v_out,
    output logic [RW-1:0]           r_out,
    output logic                    spike
);
    localparam int SW = WIDTH + 2;
    localparam logic signed [SW-1:0] THR = SW'(THRESHOLD);

    logic signed [SW-1:0]    sum;
    logic signed [WIDTH-1:0] v_sat;

    always_comb begin
        // Two guard bits make V + A - LEAK exact before clamping.
        sum   = SW'(v_in) + SW'(a_in) - SW'(LEAK);
        v_sat = WIDTH'(sat_clamp(64'(sum), WIDTH));

        v_out = v_in;
        r_out = r_in;
        spike = 1'b0;

        if (r_in != '0) begin
            r_out = r_in - 1'b1;
        end else if (SW'(v_sat) >= THR) begin
            v_out = WIDTH'(RESET_POTENTIAL);
            r_out = RW'(REFRACTORY_CYCLES);
            spike = 1'b1;
        end else begin
            v_out = v_sat;
        end
    end
endmodule

// File: rtl/lif_timestep_scheduler.sv
// Sweeps all neurons through one shared LIF update per tick, one neuron per cycle (neuron k at T+1+k).
// A pending spike not accepted by spk_ready freezes the sweep; done waits for the last event to leave.
module lif_timestep_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS         = 16,
    parameter int WIDTH             = 16,
    parameter int THRESHOLD         = 1000,
    parameter int LEAK              = 10,
    parameter int RESET_POTENTIAL   = 0,
    parameter int REFRACTORY_CYCLES = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    lif_timestep_scheduler_if.slave       bus,
    output logic                          busy,
    output logic                          done,
    output logic                          tick_overrun
);
    localparam int IW = cnt_width(N_NEURONS);
    localparam int RW = cnt_width(REFRACTORY_CYCLES + 1);

    lif_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    logic signed [WIDTH-1:0] v_q [N_NEURONS];
    logic signed [WIDTH-1:0] v_d [N_NEURONS];
    logic signed [WIDTH-1:0] a_q [N_NEURONS];
    logic signed [WIDTH-1:0] a_d [N_NEURONS];
    logic [RW-1:0]           r_q [N_NEURONS];
    logic [RW-1:0]           r_d [N_NEURONS];

    logic          spk_valid_q, spk_valid_d;
    logic [IW-1:0] spk_idx_q, spk_idx_d;

    logic stall;
    logic process;

    logic signed [WIDTH-1:0] u_v;
    logic [RW-1:0]           u_r;
    logic                    u_spike;

    lif_update_unit #(
        .WIDTH             (WIDTH),
        .THRESHOLD         (THRESHOLD),
        .LEAK              (LEAK),
        .RESET_POTENTIAL   (RESET_POTENTIAL),
        .REFRACTORY_CYCLES (REFRACTORY_CYCLES),
        .RW                (RW)
    ) u_update (
        .v_in  (v_q[idx_q]),
        .a_in  (a_q[idx_q]),
        .r_in  (r_q[idx_q]),
        .v_out (u_v),
        .r_out (u_r),
        .spike (u_spike)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        done         = 1'b0;
        tick_overrun = 1'b0;
        process      = 1'b0;
        busy         = (state_q != ST_IDLE);
        stall        = spk_valid_q && !bus.spk_ready;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                tick_overrun = tick;
                if (!stall) begin
                    process = 1'b1;
                    if (idx_q == IW'(N_NEURONS - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // done shares its cycle with busy, so a tick here still counts as an overrun.
                tick_overrun = tick;
                if (!stall) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        v_d         = v_q;
        r_d         = r_q;
        a_d         = a_q;
        spk_valid_d = spk_valid_q;
        spk_idx_d   = spk_idx_q;

        if (spk_valid_q && bus.spk_ready) begin
            spk_valid_d = 1'b0;
        end

        if (process) begin
            v_d[idx_q] = u_v;
            r_d[idx_q] = u_r;
            a_d[idx_q] = '0;
            if (u_spike) begin
                spk_valid_d = 1'b1;
                spk_idx_d   = idx_q;
            end
        end

        // Applied after the sweep clear so a same-cycle write lands in the next timestep.
        if (bus.cur_wr_en) begin
            a_d[bus.cur_wr_idx] = WIDTH'(sat_add(64'(a_d[bus.cur_wr_idx]),
                                                 64'(bus.cur_wr_data), WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i] <= '0;
                r_q[i] <= '0;
                a_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            spk_valid_q <= spk_valid_d;
            spk_idx_q   <= spk_idx_d;
            v_q         <= v_d;
            r_q         <= r_d;
            a_q         <= a_d;
        end
    end

    assign bus.spk_valid = spk_valid_q;
    assign bus.spk_idx   = spk_idx_q;

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Bench for lif_timestep_scheduler (4 neurons): directed scenarios plus randomized timesteps,
// spike events scored against a reference neuron model by an independent monitor.
module tb_lif_timestep_scheduler;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int IW   = 2;
    localparam int THR  = 1000;
    localparam int LEAK = 10;
    localparam int REFR = 10;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic busy;
    logic done;
    logic tick_overrun;

    lif_timestep_scheduler_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    lif_timestep_scheduler #(.N_NEURONS(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .tick_overrun (tick_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int stall_cnt = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    int exp_q[$];
    bit rdy_rand = 1'b0;
    bit rdy_force = 1'b1;

    int mv[N];
    int mr[N];
    int ma[N];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mr[i] = 0;
            ma[i] = 0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_write(input int i, input int d);
        ma[i] = sat16(ma[i] + d);
    endfunction

    // One whole timestep, neurons in ascending order; spikes queued in emission order.
    function automatic void model_tick();
        for (int i = 0; i < N; i++) begin
            if (mr[i] > 0) begin
                mr[i] = mr[i] - 1;
            end else begin
                int vn;
                vn = sat16(mv[i] + ma[i] - LEAK);
                if (vn >= THR) begin
                    mv[i] = 0;
                    mr[i] = REFR;
                    exp_q.push_back(i);
                end else begin
                    mv[i] = vn;
                end
            end
            ma[i] = 0;
        end
    endfunction

    always @(posedge clk) begin
        #1;
        bus.spk_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.spk_valid && !bus.spk_ready) stall_cnt++;
            if (bus.spk_valid && bus.spk_ready) begin
                if (exp_q.size() == 0) check("unexpected_spike", int'(bus.spk_idx), -1);
                else check("spike_idx", int'(bus.spk_idx), exp_q.pop_front());
            end
            if (done) done_cnt++;
            if (tick_overrun) ovr_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        bus.cur_wr_en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wr(input int i, input int d, input bit upd_model);
        bus.cur_wr_en   = 1'b1;
        bus.cur_wr_idx  = IW'(i);
        bus.cur_wr_data = W'(d);
        if (upd_model) model_write(i, d);
        step();
        bus.cur_wr_en = 1'b0;
    endtask

    // Each cycle with an unaccepted event delays completion by exactly one cycle.
    task automatic wait_done(input int t0, input int s0, input bit tick_at_done);
        bit got = 1'b0;
        int n = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
        check("done_seen", int'(got), 1);
        if (got) check("done_cycle", cyc, t0 + N + 1 + (stall_cnt - s0));
        if (got && tick_at_done) begin
            tick = 1'b1;
            #1;
            check("overrun_at_done", int'(tick_overrun), 1);
        end
        step();
        tick = 1'b0;
        if (got && tick_at_done) begin
            @(negedge clk);
            check("idle_after_done_tick", int'(busy), 0);
            step();
        end
        check("events_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Optional write of d to neuron j in the cycle neuron k is being processed.
    task automatic run_ts(input bit mid_en, input int k, input int j, input int d,
                          input bit tick_at_done);
        int t0;
        int s0;
        if (mid_en && j > k) model_write(j, d);
        model_tick();
        if (mid_en && j <= k) model_write(j, d);
        t0 = cyc;
        s0 = stall_cnt;
        tick = 1'b1;
        step();
        tick = 1'b0;
        if (mid_en) begin
            repeat (k) step();
            wr(j, d, 1'b0);
        end
        wait_done(t0, s0, tick_at_done);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int s0;
        int o0;
        int d0;
        rst = 1'b1;
        tick = 1'b0;
        bus.cur_wr_en = 1'b0;
        bus.cur_wr_idx = '0;
        bus.cur_wr_data = '0;
        do_reset();

        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_spk_valid", int'(bus.spk_valid), 0);
        check("rst_spk_idx", int'(bus.spk_idx), 0);
        check("rst_overrun", int'(tick_overrun), 0);
        step();

        // Single threshold crossing, then refractory window swallowing large inputs.
        wr(2, 1010, 1'b1);
        run_ts(1'b0, 0, 0, 0, 1'b0);
        for (int t = 0; t < 11; t++) begin
            wr(2, 2000, 1'b1);
            run_ts(1'b0, 0, 0, 0, 1'b0);
        end

        // Saturation of accumulator and potential at both rails.
        do_reset();
        wr(0, 32767, 1'b1);
        wr(0, 32767, 1'b1);
        run_ts(1'b0, 0, 0, 0, 1'b0);
        wr(1, -32768, 1'b1);
        wr(1, -32768, 1'b1);
        run_ts(1'b0, 0, 0, 0, 1'b0);
        wr(1, 32767, 1'b1);
        run_ts(1'b0, 0, 0, 0, 1'b0);
        wr(1, 1011, 1'b1);
        run_ts(1'b0, 0, 0, 0, 1'b0);
        wr(1, 21, 1'b1);
        run_ts(1'b0, 0, 0, 0, 1'b0);

        // Backpressure: event 0 must sit still while ready is low.
        do_reset();
        rdy_rand = 1'b0;
        rdy_force = 1'b0;
        wr(0, 1010, 1'b1);
        wr(1, 1010, 1'b1);
        model_tick();
        t0 = cyc;
        s0 = stall_cnt;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", int'(bus.spk_valid), 1);
            check("stall_idx", int'(bus.spk_idx), 0);
            step();
        end
        rdy_force = 1'b1;
        wait_done(t0, s0, 1'b0);
        step();

        // Overrun: second tick two cycles into a sweep.
        wr(3, 1010, 1'b1);
        model_tick();
        t0 = cyc;
        s0 = stall_cnt;
        o0 = ovr_cnt;
        d0 = done_cnt;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        tick = 1'b1;
        @(negedge clk);
        check("overrun_pulse", int'(tick_overrun), 1);
        step();
        tick = 1'b0;
        wait_done(t0, s0, 1'b0);
        repeat (6) step();
        check("overrun_count", ovr_cnt - o0, 1);
        check("done_count", done_cnt - d0, 1);

        // Writes racing the sweep: same neuron defers, later neuron counts now.
        run_ts(1'b1, 2, 2, 1010, 1'b0);
        run_ts(1'b0, 0, 0, 0, 1'b0);
        run_ts(1'b1, 0, 3, 1010, 1'b0);
        run_ts(1'b1, 3, 1, 1010, 1'b1);
        run_ts(1'b0, 0, 0, 0, 1'b0);

        // Reset while neuron 2 is being processed aborts the sweep and clears all state.
        do_reset();
        wr(0, 1010, 1'b1);
        run_ts(1'b0, 0, 0, 0, 1'b0);
        wr(3, 1020, 1'b0);
        d0 = done_cnt;
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_spk_valid", int'(bus.spk_valid), 0);
        check("abort_done", int'(done), 0);
        repeat (8) step();
        check("abort_no_done", done_cnt - d0, 0);
        wr(0, 1010, 1'b1);
        run_ts(1'b0, 0, 0, 0, 1'b0);
        run_ts(1'b0, 0, 0, 0, 1'b0);

        // Random inputs with random backpressure.
        rdy_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) begin
                int r;
                int d;
                r = $urandom_range(0, 9);
                if (r == 0) d = 32767;
                else if (r == 1) d = -32768;
                else d = int'($urandom_range(0, 1400)) - 300;
                wr($urandom_range(0, N - 1), d, 1'b1);
            end
            run_ts(1'b0, 0, 0, 0, ($urandom_range(0, 7) == 0));
        end

        // Random in-sweep writes with ready held high.
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        step();
        for (int t = 0; t < 20; t++) begin
            run_ts(1'b1, $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                   $urandom_range(0, 1200), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
